// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage RV32I pipeline: IF/ID register, decode,
// register-file read with same-cycle WB bypass, load-use hazard detection and ID/EX register.
module id_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  output logic            id_stall,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_rdata,
  input  logic [XLEN-1:0] rs2_rdata,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_we,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_MISC   = 7'h0F;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_we;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
  } idex_t;

  // Bubble and reset value of the ID/EX slot: everything zero, opcode reads as a NOP.
  function automatic idex_t idex_bubble();
    idex_t b;
    b        = '0;
    b.opcode = OP_IMM;
    return b;
  endfunction

  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  idex_t           idex_q, idex_d, dec;

  logic [6:0]      opcode;
  logic [4:0]      rd_idx;
  logic [31:0]     imm;
  logic            legal, writes_rd, rs1_used, rs2_used, load_use;

  assign opcode    = ifid_instr_q[6:0];
  assign rd_idx    = ifid_instr_q[11:7];
  assign rs1_addr  = ifid_instr_q[19:15];
  assign rs2_addr  = ifid_instr_q[24:20];

  assign legal     = opcode inside {OP_LOAD, OP_MISC, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
                                    OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM};
  assign writes_rd = opcode inside {OP_LOAD, OP_IMM, OP_AUIPC, OP_REG, OP_LUI, OP_JALR, OP_JAL};
  assign rs1_used  = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign rs2_used  = opcode inside {OP_REG, OP_STORE, OP_BRANCH};

  always_comb begin
    // NOTE: assign a default before the case so no path leaves imm unassigned (no latch).
    imm = '0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
      OP_STORE:  imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
      OP_BRANCH: imm = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                        ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {ifid_instr_q[31:12], 12'b0};
      OP_JAL:    imm = {{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                        ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};
      default:   imm = '0;
    endcase
  end

  // A load in EX whose rd feeds an operand this instruction actually reads.
  assign load_use = ifid_valid_q && idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0)
                 && ((rs1_used && (idex_q.rd == rs1_addr)) || (rs2_used && (idex_q.rd == rs2_addr)));
  assign id_stall = load_use && !flush;

  always_comb begin
    dec           = idex_bubble();
    dec.valid     = 1'b1;
    dec.pc        = ifid_pc_q;
    // x0 is never bypassed, so a WB to x0 cannot leak into an operand.
    dec.rs1_val   = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) ? wb_data : rs1_rdata;
    dec.rs2_val   = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) ? wb_data : rs2_rdata;
    dec.imm       = imm;
    dec.rs1       = rs1_addr;
    dec.rs2       = rs2_addr;
    dec.rd        = rd_idx;
    dec.opcode    = opcode;
    dec.funct3    = ifid_instr_q[14:12];
    dec.funct7b5  = ifid_instr_q[30];
    dec.reg_we    = legal && writes_rd && (rd_idx != 5'd0);
    dec.mem_read  = (opcode == OP_LOAD);
    dec.mem_write = (opcode == OP_STORE);
    dec.illegal   = !legal;
  end

  always_comb begin
    ifid_valid_d = if_valid;
    ifid_pc_d    = if_pc;
    ifid_instr_d = if_instr;
    idex_d       = dec;
    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      idex_d       = idex_bubble();
    end else if (load_use) begin
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      idex_d       = idex_bubble();
    end else if (!ifid_valid_q) begin
      idex_d       = idex_bubble();
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      idex_q       <= idex_bubble();
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      idex_q       <= idex_d;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_pc        = idex_q.pc;
  assign ex_rs1_val   = idex_q.rs1_val;
  assign ex_rs2_val   = idex_q.rs2_val;
  assign ex_imm       = idex_q.imm;
  assign ex_rs1       = idex_q.rs1;
  assign ex_rs2       = idex_q.rs2;
  assign ex_rd        = idex_q.rd;
  assign ex_opcode    = idex_q.opcode;
  assign ex_funct3    = idex_q.funct3;
  assign ex_funct7b5  = idex_q.funct7b5;
  assign ex_reg_we    = idex_q.reg_we;
  assign ex_mem_read  = idex_q.mem_read;
  assign ex_mem_write = idex_q.mem_write;
  assign ex_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against an instruction-level model of the decode stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        flush;
  logic        id_stall;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_we, ex_mem_read, ex_mem_write, ex_illegal;

  logic [31:0] rf [32];
  assign rs1_rdata = rf[rs1_addr];
  assign rs2_rdata = rf[rs2_addr];

  id_stage #(.XLEN(32), .NOP_INSTR(32'h13)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush), .id_stall(id_stall), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level view of what EX should see.
  typedef struct {
    logic        valid;
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5, we, mr, mw, ill;
  } ex_t;

  function automatic ex_t tb_bubble();
    ex_t e;
    e.valid = 1'b0; e.pc = '0; e.v1 = '0; e.v2 = '0; e.imm = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.opc = 7'h13; e.f3 = '0;
    e.f7b5 = 1'b0; e.we = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.ill = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] x, input int n);
    logic [31:0] m;
    m = 32'h1 << (n - 1);
    return (x ^ m) - m;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_we && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  function automatic ex_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] v1, input logic [31:0] v2);
    ex_t  e;
    logic [6:0] op;
    logic legal, writes;
    op     = ins[6:0];
    e.valid = 1'b1; e.pc = pc; e.v1 = v1; e.v2 = v2;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.opc = op; e.f3 = ins[14:12]; e.f7b5 = ins[30];
    case (op)
      7'h03, 7'h13, 7'h67: e.imm = sext(ins >> 20, 12);
      7'h23: e.imm = sext(((ins >> 25) << 5) | ((ins >> 7) & 32'h1F), 12);
      7'h63: e.imm = sext((((ins >> 31) & 32'h1) << 12) | (((ins >> 7) & 32'h1) << 11)
                        | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1), 13);
      7'h37, 7'h17: e.imm = ins & 32'hFFFF_F000;
      7'h6F: e.imm = sext((((ins >> 31) & 32'h1) << 20) | (((ins >> 12) & 32'hFF) << 12)
                        | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1), 21);
      default: e.imm = 32'h0;
    endcase
    legal  = op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    writes = op inside {7'h03, 7'h13, 7'h17, 7'h33, 7'h37, 7'h67, 7'h6F};
    e.ill = !legal;
    e.we  = legal && writes && (e.rd != 5'd0);
    e.mr  = (op == 7'h03);
    e.mw  = (op == 7'h23);
    return e;
  endfunction

  // Model state: the instruction waiting in decode and the bundle EX should hold.
  logic        m_valid;
  logic [31:0] m_pc, m_instr;
  ex_t         m_ex;
  logic        m_stall = 1'b0;

  initial begin
    m_valid = 1'b0; m_pc = '0; m_instr = 32'h13; m_ex = tb_bubble();
    forever begin
      @(negedge clk);
      begin
        logic [4:0] r1, r2;
        logic [6:0] op;
        ex_t        nx;
        if (rst) begin
          m_valid = 1'b0; m_pc = '0; m_instr = 32'h13; m_ex = tb_bubble();
        end
        r1 = m_instr[19:15];
        r2 = m_instr[24:20];
        op = m_instr[6:0];
        m_stall = !rst && !flush && m_valid && m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0)
               && ((uses_rs1(op) && m_ex.rd == r1) || (uses_rs2(op) && m_ex.rd == r2));
        check("id_stall", id_stall, m_stall);
        check("rs1_addr", rs1_addr, r1);
        check("rs2_addr", rs2_addr, r2);
        check("ex_valid", ex_valid, m_ex.valid);
        check("ex_reg_we", ex_reg_we, m_ex.we);
        check("ex_mem_read", ex_mem_read, m_ex.mr);
        check("ex_mem_write", ex_mem_write, m_ex.mw);
        check("ex_illegal", ex_illegal, m_ex.ill);
        if (m_ex.valid || rst) begin
          check("ex_pc", ex_pc, m_ex.pc);
          check("ex_rs1_val", ex_rs1_val, m_ex.v1);
          check("ex_rs2_val", ex_rs2_val, m_ex.v2);
          check("ex_imm", ex_imm, m_ex.imm);
          check("ex_rs1", ex_rs1, m_ex.rs1);
          check("ex_rs2", ex_rs2, m_ex.rs2);
          check("ex_rd", ex_rd, m_ex.rd);
          check("ex_opcode", ex_opcode, m_ex.opc);
          check("ex_funct3", ex_funct3, m_ex.f3);
          check("ex_funct7b5", ex_funct7b5, m_ex.f7b5);
        end
        if (!rst) begin
          if (flush || m_stall || !m_valid) nx = tb_bubble();
          else nx = model_decode(m_instr, m_pc, operand(r1), operand(r2));
          if (flush) begin
            m_valid = 1'b0; m_pc = '0; m_instr = 32'h13;
          end else if (!m_stall) begin
            m_valid = if_valid; m_pc = if_pc; m_instr = if_instr;
          end
          m_ex = nx;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (wb_we && wb_rd != 5'd0) rf[wb_rd] = wb_data;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r, o;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 12);
    case (sel)
      0, 1:    r[6:0] = 7'h03;
      2:       r[6:0] = 7'h13;
      3:       r[6:0] = 7'h33;
      4:       r[6:0] = 7'h23;
      5:       r[6:0] = 7'h63;
      6:       r[6:0] = 7'h37;
      7:       r[6:0] = 7'h17;
      8:       r[6:0] = 7'h6F;
      9:       r[6:0] = 7'h67;
      10:      r[6:0] = 7'h0F;
      11:      r[6:0] = 7'h73;
      default: begin o = $urandom; r[6:0] = o[6:0]; end
    endcase
    r[11:7]  = 5'($urandom_range(0, 4));
    r[19:15] = 5'($urandom_range(0, 4));
    r[24:20] = 5'($urandom_range(0, 4));
    return r;
  endfunction

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI   = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] LW     = 32'h0000_A103;  // lw x2,0(x1)
  localparam logic [31:0] ADD    = 32'h0021_01B3;  // add x3,x2,x2
  localparam logic [31:0] ADDI_5 = 32'h0002_8313;  // addi x6,x5,0

  initial begin
    logic [31:0] pc_ctr;
    rst = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    drive(1'b0, '0, NOP);
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
    #1;
    check("reset ex_valid", ex_valid, 1'b0);
    check("reset ex_opcode", ex_opcode, 7'h13);
    check("reset id_stall", id_stall, 1'b0);
    check("reset ex_imm", ex_imm, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Single addi reaches EX two edges after it is presented.
    drive(1'b1, 32'h0, ADDI); tick();
    drive(1'b0, 32'h4, NOP);  tick();
    check("addi ex_valid", ex_valid, 1'b1);
    check("addi ex_rd", ex_rd, 5'd1);
    check("addi ex_imm", ex_imm, 32'd5);
    check("addi ex_reg_we", ex_reg_we, 1'b1);

    // Load-use: one stall cycle, one bubble, consumer issued once.
    drive(1'b1, 32'h8, LW);  tick();
    drive(1'b1, 32'hC, ADD); tick();
    check("lu stall", id_stall, 1'b1);
    check("lu ex_mem_read", ex_mem_read, 1'b1);
    tick();
    check("lu bubble", ex_valid, 1'b0);
    check("lu stall released", id_stall, 1'b0);
    drive(1'b0, 32'h10, NOP); tick();
    check("lu add valid", ex_valid, 1'b1);
    check("lu add rd", ex_rd, 5'd3);
    check("lu add pc", ex_pc, 32'hC);
    tick();
    check("lu add once", ex_valid, 1'b0);

    // WB bypass into rs1, then a WB to x0 that must not bypass.
    rf[5] = 32'h0;
    drive(1'b1, 32'h20, ADDI_5); tick();
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    drive(1'b0, 32'h24, NOP);
    #1 check("byp rs1_addr", rs1_addr, 5'd5);
    tick();
    check("byp ex_rs1_val", ex_rs1_val, 32'hDEAD_BEEF);
    wb_we = 1'b0;
    rf[5] = 32'h1234_5678;
    drive(1'b1, 32'h28, ADDI_5); tick();
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
    drive(1'b0, 32'h2C, NOP); tick();
    check("nobyp ex_rs1_val", ex_rs1_val, 32'h1234_5678);
    wb_we = 1'b0;

    // Immediate formats streamed back to back.
    drive(1'b1, 32'h30, 32'hFE11_2E23); tick();
    drive(1'b1, 32'h34, 32'hFE00_0EE3); tick();
    check("imm sw", ex_imm, 32'hFFFF_FFFC);
    drive(1'b1, 32'h38, 32'h0080_006F); tick();
    check("imm beq", ex_imm, 32'hFFFF_FFFC);
    drive(1'b1, 32'h3C, 32'h1234_50B7); tick();
    check("imm jal", ex_imm, 32'd8);
    drive(1'b0, 32'h40, NOP); tick();
    check("imm lui", ex_imm, 32'h1234_5000);

    // Flush wins over a pending load-use stall.
    drive(1'b1, 32'h44, LW);  tick();
    drive(1'b1, 32'h48, ADD); tick();
    flush = 1'b1;
    drive(1'b0, 32'h80, NOP);
    #1 check("flush masks stall", id_stall, 1'b0);
    tick();
    flush = 1'b0;
    check("flush bubble", ex_valid, 1'b0);
    tick();
    check("flush no stale", ex_valid, 1'b0);
    check("flush no stall", id_stall, 1'b0);

    // Unknown opcode, then an asynchronous reset mid-stream.
    drive(1'b1, 32'h50, 32'h0000_00FF); tick();
    drive(1'b0, 32'h54, NOP); tick();
    check("illegal flag", ex_illegal, 1'b1);
    check("illegal reg_we", ex_reg_we, 1'b0);
    drive(1'b1, 32'h60, ADDI); tick(); tick();
    check("pre-reset valid", ex_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("async ex_valid", ex_valid, 1'b0);
    check("async ex_opcode", ex_opcode, 7'h13);
    check("async ex_rd", ex_rd, 5'd0);
    check("async ex_reg_we", ex_reg_we, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("post-reset 1 edge", ex_valid, 1'b0);
    tick();
    check("post-reset 2 edges", ex_valid, 1'b1);

    // Randomized traffic; IF holds its instruction while decode stalls.
    pc_ctr = 32'h100;
    for (int c = 0; c < 3000; c++) begin
      if (!m_stall) begin
        if_valid = ($urandom_range(0, 99) < 85);
        if_pc    = pc_ctr;
        if_instr = rand_instr();
        pc_ctr  += 32'd4;
      end
      flush   = ($urandom_range(0, 9) == 0);
      wb_we   = 1'($urandom_range(0, 1));
      wb_rd   = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      tick();
    end

    drive(1'b0, '0, NOP);
    flush = 1'b0; wb_we = 1'b0;
    tick(); tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
